// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key-event path: prefix scan codes,
// prefix-tracking states and the 10-bit key-event record.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        PFX_IDLE    = 2'd0,
        PFX_EXT     = 2'd1,
        PFX_BRK     = 2'd2,
        PFX_EXT_BRK = 2'd3
    } prefix_state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    localparam int KEY_EVENT_W = $bits(key_event_t);

    // Status byte layout seen by the processor on the status port.
    function automatic logic [7:0] status_byte(input logic not_empty, input logic full,
                                               input logic overflow, input key_event_t head);
        return {not_empty, full, overflow, head.brk, head.ext, 3'b000};
    endfunction

endpackage

// File: rtl/ps2_keycode_fifo_if.sv
// Bus between the PS/2 byte receiver / PicoBlaze I/O side (master) and
// the key-event FIFO block (slave).
interface ps2_keycode_fifo_if;

    logic       rx_done_tick;
    logic [7:0] rx_byte;
    logic [7:0] port_id;
    logic       read_strobe;
    logic [7:0] in_data;
    logic       not_empty;
    logic       overflow;

    modport master (
        output rx_done_tick, rx_byte, port_id, read_strobe,
        input  in_data, not_empty, overflow
    );

    modport slave (
        input  rx_done_tick, rx_byte, port_id, read_strobe,
        output in_data, not_empty, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   FULL_COUNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers define validity,
    // and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ps2_keycode_fifo.sv
// PS/2 key-event buffer: folds E0/F0 prefixes into key events, queues them,
// and serves data/status reads on the PicoBlaze I/O bus.
module ps2_keycode_fifo
    import ps2_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter logic [7:0] DATA_PORT    = 8'h02,
    parameter logic [7:0] STATUS_PORT  = 8'h03,
    parameter int         REPORT_BREAK = 0
) (
    input logic                clk,
    input logic                reset,
    ps2_keycode_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    prefix_state_t   state;
    prefix_state_t   state_next;
    key_event_t      ev;
    logic            ev_valid;
    logic            push;
    logic            pop_req;
    logic            status_rd;
    logic            drop;
    logic            overflow;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    key_event_t      head_raw;
    key_event_t      head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= PFX_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ev_valid   = 1'b0;
        ev.code    = bus.rx_byte;
        ev.brk     = (state == PFX_BRK) || (state == PFX_EXT_BRK);
        ev.ext     = (state == PFX_EXT) || (state == PFX_EXT_BRK);
        if (bus.rx_done_tick) begin
            if (bus.rx_byte == SC_EXT) begin
                state_next = (state == PFX_IDLE || state == PFX_EXT) ? PFX_EXT : PFX_EXT_BRK;
            end else if (bus.rx_byte == SC_BRK) begin
                state_next = (state == PFX_IDLE || state == PFX_BRK) ? PFX_BRK : PFX_EXT_BRK;
            end else begin
                ev_valid   = 1'b1;
                state_next = PFX_IDLE;
            end
        end
    end

    // A suppressed break event still completes the prefix sequence above.
    assign push      = ev_valid && (!ev.brk || (REPORT_BREAK != 0));
    assign pop_req   = bus.read_strobe && (bus.port_id == DATA_PORT);
    assign status_rd = bus.read_strobe && (bus.port_id == STATUS_PORT);
    assign drop      = push && full && !pop_req;

    sync_fifo #(
        .WIDTH (KEY_EVENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop_req),
        .din   (ev),
        .dout  (head_raw),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A drop in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (status_rd) overflow <= 1'b0;
    end

    assign head          = empty ? key_event_t'('0) : head_raw;
    assign bus.not_empty = (count != '0);
    assign bus.overflow  = overflow;

    always_comb begin
        bus.in_data = 8'h00;
        if (bus.port_id == DATA_PORT)
            bus.in_data = head.code;
        else if (bus.port_id == STATUS_PORT)
            bus.in_data = status_byte(bus.not_empty, full, overflow, head);
    end

endmodule

// File: tb/tb_ps2_keycode_fifo.sv
// Drives two instances (break events suppressed / reported) with the same byte
// stream and compares them against a queue-based model of key events.
module tb_ps2_keycode_fifo;

    localparam int         DEPTH       = 8;
    localparam logic [7:0] DATA_PORT   = 8'h02;
    localparam logic [7:0] STATUS_PORT = 8'h03;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_keycode_fifo_if bus0 ();
    ps2_keycode_fifo_if bus1 ();

    ps2_keycode_fifo #(.DEPTH(DEPTH), .DATA_PORT(DATA_PORT), .STATUS_PORT(STATUS_PORT),
                       .REPORT_BREAK(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    ps2_keycode_fifo #(.DEPTH(DEPTH), .DATA_PORT(DATA_PORT), .STATUS_PORT(STATUS_PORT),
                       .REPORT_BREAK(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: pending-prefix flags plus one event queue per instance.
    bit         p_ext, p_brk;
    logic [9:0] mq0[$];
    logic [9:0] mq1[$];
    bit         ovf0, ovf1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_in(input int d, input logic [7:0] pid);
        logic [9:0] h;
        int         n;
        bit         o;
        if (d == 0) begin
            n = mq0.size(); h = (n != 0) ? mq0[0] : 10'h000; o = ovf0;
        end else begin
            n = mq1.size(); h = (n != 0) ? mq1[0] : 10'h000; o = ovf1;
        end
        if (pid == DATA_PORT)   return h[7:0];
        if (pid == STATUS_PORT) return {n != 0, n == DEPTH, o, h[9], h[8], 3'b000};
        return 8'h00;
    endfunction

    task automatic model_fifo(input int d, input bit ev_valid, input logic [9:0] ev,
                              input bit pop_req, input bit st_rd);
        bit pushes;
        bit drop;
        pushes = ev_valid && (ev[9] == 1'b0 || d == 1);
        drop   = 1'b0;
        if (d == 0) begin
            if (pop_req && mq0.size() != 0) void'(mq0.pop_front());
            if (pushes) begin
                if (mq0.size() < DEPTH) mq0.push_back(ev); else drop = 1'b1;
            end
            if (drop) ovf0 = 1'b1; else if (st_rd) ovf0 = 1'b0;
        end else begin
            if (pop_req && mq1.size() != 0) void'(mq1.pop_front());
            if (pushes) begin
                if (mq1.size() < DEPTH) mq1.push_back(ev); else drop = 1'b1;
            end
            if (drop) ovf1 = 1'b1; else if (st_rd) ovf1 = 1'b0;
        end
    endtask

    task automatic model_step(input logic tick, input logic [7:0] b,
                              input logic [7:0] pid, input logic rs);
        bit         ev_valid;
        logic [9:0] ev;
        ev_valid = 1'b0;
        ev       = 10'h000;
        if (tick) begin
            if (b == 8'hE0)      p_ext = 1'b1;
            else if (b == 8'hF0) p_brk = 1'b1;
            else begin
                ev       = {p_brk, p_ext, b};
                ev_valid = 1'b1;
                p_ext    = 1'b0;
                p_brk    = 1'b0;
            end
        end
        model_fifo(0, ev_valid, ev, rs && pid == DATA_PORT, rs && pid == STATUS_PORT);
        model_fifo(1, ev_valid, ev, rs && pid == DATA_PORT, rs && pid == STATUS_PORT);
    endtask

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        ovf0 = 1'b0; ovf1 = 1'b0;
        p_ext = 1'b0; p_brk = 1'b0;
    endtask

    task automatic drive(input logic tick, input logic [7:0] b,
                         input logic [7:0] pid, input logic rs);
        bus0.rx_done_tick = tick; bus0.rx_byte = b; bus0.port_id = pid; bus0.read_strobe = rs;
        bus1.rx_done_tick = tick; bus1.rx_byte = b; bus1.port_id = pid; bus1.read_strobe = rs;
    endtask

    // One clock: inputs applied just after a rising edge, read data sampled
    // at the falling edge, flags sampled 1 ns after the next rising edge.
    task automatic cycle(input logic tick, input logic [7:0] b, input logic [7:0] pid,
                         input logic rs, input string tag);
        drive(tick, b, pid, rs);
        @(negedge clk);
        if (rs) begin
            check({tag, "_in0"}, bus0.in_data, exp_in(0, pid));
            check({tag, "_in1"}, bus1.in_data, exp_in(1, pid));
        end
        @(posedge clk);
        model_step(tick, b, pid, rs);
        #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check({tag, "_ne0"}, {7'd0, bus0.not_empty}, {7'd0, mq0.size() != 0});
        check({tag, "_ne1"}, {7'd0, bus1.not_empty}, {7'd0, mq1.size() != 0});
        check({tag, "_ov0"}, {7'd0, bus0.overflow}, {7'd0, ovf0});
        check({tag, "_ov1"}, {7'd0, bus1.overflow}, {7'd0, ovf1});
    endtask

    task automatic peek(input logic [7:0] pid);
        drive(1'b0, 8'h00, pid, 1'b0);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] pid;
        logic       tick;
        logic       rs;

        model_reset();
        drive(1'b0, 8'h00, DATA_PORT, 1'b0);
        #1;
        check("rst_ne0", {7'd0, bus0.not_empty}, 8'h00);
        check("rst_ov1", {7'd0, bus1.overflow}, 8'h00);
        check("rst_data0", bus0.in_data, 8'h00);
        #11 reset = 1'b1;
        @(posedge clk); #1;

        // Single make code, then pop it.
        cycle(1'b1, 8'h1C, 8'h00, 1'b0, "make1c");
        check("make1c_ne_const", {7'd0, bus0.not_empty}, 8'h01);
        cycle(1'b0, 8'h00, DATA_PORT, 1'b1, "pop1c");
        check("pop1c_empty_const", {7'd0, bus1.not_empty}, 8'h00);

        // Extended break sequence.
        cycle(1'b1, 8'hE0, 8'h00, 1'b0, "e0");
        cycle(1'b1, 8'hF0, 8'h00, 1'b0, "f0");
        cycle(1'b1, 8'h75, 8'h00, 1'b0, "k75");
        peek(STATUS_PORT);
        check("brk_status1", bus1.in_data, 8'h98);
        check("brk_status0", bus0.in_data, 8'h00);
        cycle(1'b0, 8'h00, DATA_PORT, 1'b1, "pop75");
        cycle(1'b1, 8'h1C, 8'h00, 1'b0, "after_brk");
        peek(STATUS_PORT);
        check("after_brk_status0", bus0.in_data, 8'h80);
        cycle(1'b0, 8'h00, DATA_PORT, 1'b1, "pop_after_brk");

        // Overfill with make codes; the ninth is dropped.
        for (int i = 0; i <= DEPTH; i++)
            cycle(1'b1, 8'h10 + 8'(i), 8'h00, 1'b0, "fill");
        peek(STATUS_PORT);
        check("full_status0", bus0.in_data, 8'hE0);
        cycle(1'b0, 8'h00, STATUS_PORT, 1'b1, "clr_ovf");
        check("clr_ovf_const", {7'd0, bus0.overflow}, 8'h00);
        cycle(1'b1, 8'h55, DATA_PORT, 1'b1, "full_push_pop");
        check("full_push_pop_ovf", {7'd0, bus1.overflow}, 8'h00);
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 8'h00, DATA_PORT, 1'b1, "drain");
        cycle(1'b0, 8'h00, DATA_PORT, 1'b1, "pop_empty");

        // Empty FIFO: push and pop together stores the entry.
        cycle(1'b1, 8'h2A, DATA_PORT, 1'b1, "empty_push_pop");
        cycle(1'b0, 8'h00, DATA_PORT, 1'b1, "pop2a");

        // Drop coinciding with a status read: overflow stays set.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 8'h30 + 8'(i), 8'h00, 1'b0, "fill2");
        cycle(1'b1, 8'h66, STATUS_PORT, 1'b1, "drop_vs_clr");
        check("drop_vs_clr_const", {7'd0, bus0.overflow}, 8'h01);

        // Reset in the middle of an E0 prefix with data queued.
        cycle(1'b1, 8'hE0, 8'h00, 1'b0, "pre_rst_e0");
        reset = 1'b0;
        #5;
        model_reset();
        check("midrst_ne1", {7'd0, bus1.not_empty}, 8'h00);
        check("midrst_ov0", {7'd0, bus0.overflow}, 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 8'h1C, 8'h00, 1'b0, "post_rst");
        peek(STATUS_PORT);
        check("post_rst_status1", bus1.in_data, 8'h80);
        peek(DATA_PORT);
        check("post_rst_data0", bus0.in_data, 8'h1C);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            tick = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 5))
                0, 1:    pid = DATA_PORT;
                2:       pid = STATUS_PORT;
                default: pid = 8'($urandom_range(0, 255));
            endcase
            rs = ($urandom_range(0, 9) < 4);
            cycle(tick, b, pid, rs, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
